immediate_extender_pipe: RTL and testbench
==========================================

// Module: immediate_extender_pipe
// PURPOSE
//  Registered, handshaked immediate generator for the decode stage; parametrised successor of the
//  combinational extender. Covers all RV formats (I, shamt, S, B, U, J) for RV32 and RV64.
//  Sits between instruction fetch/decode and the ID/EX register. Accepts {Instr, ImmSrc} on a
//  valid/ready input port and emits the sign-extended Imm on a valid/ready output port.
//  A 2-entry skid buffer keeps full throughput with a registered in_ready.
// PARAMETERS
//  BIT_COUNT   32   output immediate width (XLEN). Legal values: 32 or 64. Elaboration error otherwise.
//  WORD_SIZE   32   instruction width. Fixed at 32.
// PORTS
//  clk         in   1          rising-edge clock
//  reset_n     in   1          asynchronous, active-low reset
//  flush       in   1          synchronous pipeline flush; drops all buffered entries
//  in_valid    in   1          Instr/ImmSrc valid
//  in_ready    out  1          buffer can accept (registered)
//  ImmSrc      in   immSrc     HighLevelControl::immSrc format select
//  Instr       in   WORD_SIZE  raw instruction
//  out_valid   out  1          Imm valid
//  out_ready   in   1          consumer accepts
//  Imm         out  BIT_COUNT  extended immediate
//  ImmIllegal  out  1          entry at output had an unmapped ImmSrc (Imm forced to 0)
// BEHAVIOUR
//  Reset (reset_n=0, async): state EMPTY, out_valid=0, in_ready=1, Imm=0, ImmIllegal=0.
//  Formats (s = Instr[31], replicated to BIT_COUNT):
//   Imm11t0: {s.., Instr[31:20]}    SType: {s.., Instr[31:25], Instr[11:7]}
//   BType: {s.., Instr[7], Instr[30:25], Instr[11:8], 1'b0}
//   UType: {s.., Instr[31:12], 12'b0}; RV64 sign-extends bit 31.
//   JType: {s.., Instr[19:12], Instr[20], Instr[30:21], 1'b0}
//   Imm4t0 (shamt): zero-extended Instr[24:20] when BIT_COUNT=32, Instr[25:20] when 64.
//   No X on any output. Unmapped ImmSrc: Imm=0, ImmIllegal=1.
//  Handshake: transfer on valid&ready at the clock edge. Latency 1 cycle from input accept to
//   out_valid. out_valid/Imm/ImmIllegal stay stable while out_valid & !out_ready.
//  Skid FSM (count of held entries): EMPTY -> ONE on accept. ONE -> TWO on accept & !drain.
//   ONE -> EMPTY on drain & !accept. TWO -> ONE on drain. Accept and drain together keep the
//   count.
//  in_ready = (state != TWO), registered. Output is always the oldest entry (FIFO order).
//  Flush: next edge forces EMPTY, out_valid=0, in_ready=1. An input offered in the same cycle is
//   discarded. Flush wins over every simultaneous event.
//  Reset asserted mid-transfer: all entries dropped immediately. No partial output.
// STRUCTURE
//  HighLevelControl package: immSrc enum gains BType, UType, JType; encodings of existing members
//   are unchanged. Add localparam SHAMT_W(xlen).
//  Sub-module imm_field_decode: pure combinational {ImmSrc, Instr} -> {Imm, ImmIllegal}.
//   It is instantiated once on the input side; the skid buffer stores decoded results.
//  Top level: the skid FSM, 2 x (BIT_COUNT+1) storage registers, and the handshake logic.
// TESTING (run each for BIT_COUNT=32 and BIT_COUNT=64)
//  1 Imm11t0, Instr=0xFFF00093 -> Imm=all-ones, out_valid 1 cycle after accept.
//  2 SType 0xFE112E23 -> 0x..FFFC. BType 0xFE000CE3 -> 0x..FFF8.
//    UType 0x123450B7 -> 0x12345000. UType 0x800000B7 (RV64) -> 0xFFFFFFFF80000000.
//  3 Imm4t0, 0x03F09093: RV64 -> 63; RV32 -> 31 (upper bit ignored).
//  4 Back-pressure: out_ready=0, push A,B -> in_ready=0 on the next cycle, C is held off.
//    Release out_ready -> A, B, C emerge in order, no loss or duplication.
//  5 Flush while TWO, with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered entry dropped.
//  6 Async reset asserted between clock edges with buffer full -> outputs reset immediately.
//    Plus: illegal ImmSrc -> Imm=0, ImmIllegal=1.

Source files
------------

// File: rtl/immediate_extender_pipe_pkg.sv
// rtl/immediate_extender_pipe_pkg.sv - shared immediate-format encodings and width helpers
// Purpose: immSrc format-select enum used by decode and the immediate pipe,
//          plus the shift-amount width helper.
// Ports:   none (package)
package HighLevelControl;

  // Imm11t0/Imm4t0/SType keep their historical encodings; BType/UType/JType
  // take the next free codes. Codes 6 and 7 are unmapped.
  typedef enum logic [2:0] {
    Imm11t0 = 3'd0,
    Imm4t0  = 3'd1,
    SType   = 3'd2,
    BType   = 3'd3,
    UType   = 3'd4,
    JType   = 3'd5
  } immSrc;

  // Shift-amount field width for a given XLEN (5 bits on RV32, 6 on RV64).
  function automatic int SHAMT_W(input int xlen);
    return (xlen == 64) ? 6 : 5;
  endfunction

endpackage

// File: rtl/immediate_extender_pipe_imm_field_decode.sv
// rtl/immediate_extender_pipe_imm_field_decode.sv - combinational RV immediate field decoder
// Purpose: maps {ImmSrc, Instr} to the sign/zero-extended immediate.
// Ports:
//   ImmSrc     in   immSrc     format select
//   Instr      in   WORD_SIZE  raw instruction
//   Imm        out  BIT_COUNT  extended immediate (0 when ImmSrc is unmapped)
//   ImmIllegal out  1          ImmSrc is unmapped
module imm_field_decode
  import HighLevelControl::*;
#(
  parameter int BIT_COUNT = 32,
  parameter int WORD_SIZE = 32
) (
  input  immSrc                  ImmSrc,
  input  logic [WORD_SIZE-1:0]   Instr,
  output logic [BIT_COUNT-1:0]   Imm,
  output logic                   ImmIllegal
);

  localparam int SW = SHAMT_W(BIT_COUNT);

  logic        w_s;
  logic [63:0] w_imm_i;
  logic [63:0] w_imm_s;
  logic [63:0] w_imm_b;
  logic [63:0] w_imm_u;
  logic [63:0] w_imm_j;
  logic [63:0] w_imm_sh;
  logic [63:0] w_full;

  // Every format is built at 64 bits and truncated, so RV32 and RV64 share
  // one set of field expressions.
  assign w_s      = Instr[31];
  assign w_imm_i  = {{52{w_s}}, Instr[31:20]};
  assign w_imm_s  = {{52{w_s}}, Instr[31:25], Instr[11:7]};
  assign w_imm_b  = {{52{w_s}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
  assign w_imm_u  = {{32{w_s}}, Instr[31:12], 12'b0};
  assign w_imm_j  = {{44{w_s}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
  // Instr[25] belongs to the shift amount only on RV64.
  assign w_imm_sh = {58'b0, (SW == 6) ? Instr[25] : 1'b0, Instr[24:20]};

  always_comb begin
    w_full     = 64'b0;
    ImmIllegal = 1'b0;
    case (ImmSrc)
      Imm11t0: w_full = w_imm_i;
      Imm4t0:  w_full = w_imm_sh;
      SType:   w_full = w_imm_s;
      BType:   w_full = w_imm_b;
      UType:   w_full = w_imm_u;
      JType:   w_full = w_imm_j;
      default: ImmIllegal = 1'b1;
    endcase
  end

  assign Imm = w_full[BIT_COUNT-1:0];

endmodule

// File: rtl/immediate_extender_pipe.sv
// rtl/immediate_extender_pipe.sv - registered, handshaked immediate generator with 2-entry skid buffer
// Purpose: decodes {Instr, ImmSrc} on accept and holds up to two decoded results,
//          presenting the oldest on the output port.
// Ports:
//   clk        in   1          rising-edge clock
//   reset_n    in   1          asynchronous active-low reset
//   flush      in   1          synchronous flush, drops all entries and any offered input
//   in_valid   in   1          Instr/ImmSrc valid
//   in_ready   out  1          buffer can accept (registered)
//   ImmSrc     in   immSrc     format select
//   Instr      in   WORD_SIZE  raw instruction
//   out_valid  out  1          Imm valid
//   out_ready  in   1          consumer accepts
//   Imm        out  BIT_COUNT  extended immediate of the oldest entry
//   ImmIllegal out  1          oldest entry had an unmapped ImmSrc
module immediate_extender_pipe
  import HighLevelControl::*;
#(
  parameter int BIT_COUNT = 32,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  immSrc                ImmSrc,
  input  logic [WORD_SIZE-1:0] Instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_COUNT-1:0] Imm,
  output logic                 ImmIllegal
);

  if ((BIT_COUNT != 32) && (BIT_COUNT != 64)) begin : g_bad_bit_count
    $error("immediate_extender_pipe: BIT_COUNT must be 32 or 64");
  end
  if (WORD_SIZE != 32) begin : g_bad_word_size
    $error("immediate_extender_pipe: WORD_SIZE must be 32");
  end

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               r_in_ready;
  // Entry layout: {illegal, imm}. Slot 0 is always the oldest entry.
  logic [BIT_COUNT:0] r_slot0;
  logic [BIT_COUNT:0] r_slot1;
  logic [BIT_COUNT:0] w_slot0_nxt;
  logic [BIT_COUNT:0] w_slot1_nxt;
  logic [BIT_COUNT-1:0] w_dec_imm;
  logic               w_dec_illegal;
  logic               w_accept;
  logic               w_drain;

  imm_field_decode #(
    .BIT_COUNT (BIT_COUNT),
    .WORD_SIZE (WORD_SIZE)
  ) u_decode (
    .ImmSrc     (ImmSrc),
    .Instr      (Instr),
    .Imm        (w_dec_imm),
    .ImmIllegal (w_dec_illegal)
  );

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = (r_state != ST_EMPTY) & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_slot0_nxt = r_slot0;
    w_slot1_nxt = r_slot1;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_slot0_nxt = {w_dec_illegal, w_dec_imm};
            w_state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            w_slot0_nxt = {w_dec_illegal, w_dec_imm};
          end else if (w_accept) begin
            w_slot1_nxt = {w_dec_illegal, w_dec_imm};
            w_state_nxt = ST_TWO;
          end else if (w_drain) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a drain can happen.
          if (w_drain) begin
            w_slot0_nxt = r_slot1;
            w_state_nxt = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_slot0    <= '0;
      r_slot1    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
      r_slot0    <= w_slot0_nxt;
      r_slot1    <= w_slot1_nxt;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = (r_state != ST_EMPTY);
  assign Imm        = r_slot0[BIT_COUNT-1:0];
  assign ImmIllegal = r_slot0[BIT_COUNT];

endmodule

// File: tb/tb_immediate_extender_pipe.sv
// tb/tb_immediate_extender_pipe.sv - self-checking bench for immediate_extender_pipe (RV32 and RV64)
module tb_immediate_extender_pipe;
  import HighLevelControl::*;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  immSrc       ImmSrc;
  logic [31:0] Instr;
  logic        out_ready;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] Imm32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] Imm64;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  src;
  } ent_t;
  ent_t mq[$];

  immediate_extender_pipe #(.BIT_COUNT(32), .WORD_SIZE(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .ImmSrc(ImmSrc), .Instr(Instr), .out_valid(out_valid32), .out_ready(out_ready),
    .Imm(Imm32), .ImmIllegal(ill32)
  );

  immediate_extender_pipe #(.BIT_COUNT(64), .WORD_SIZE(32)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .ImmSrc(ImmSrc), .Instr(Instr), .out_valid(out_valid64), .out_ready(out_ready),
    .Imm(Imm64), .ImmIllegal(ill64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference immediate as an arithmetic value: {illegal, imm masked to xlen}.
  function automatic logic [64:0] ref_imm(input int xlen, input logic [31:0] ins, input logic [2:0] src);
    longint v;
    longint r;
    logic   ill;
    v   = longint'($signed(ins));
    ill = 1'b0;
    case (src)
      3'd0: r = v >>> 20;
      3'd1: r = longint'(ins[25:20]) & ((xlen == 64) ? longint'(63) : longint'(31));
      3'd2: r = ((v >>> 25) <<< 5) | longint'(ins[11:7]);
      3'd3: r = ((v >>> 31) <<< 12) | (longint'(ins[7]) <<< 11)
                | (longint'(ins[30:25]) <<< 5) | (longint'(ins[11:8]) <<< 1);
      3'd4: r = v & ~longint'(4095);
      3'd5: r = ((v >>> 31) <<< 20) | (longint'(ins[19:12]) <<< 12)
                | (longint'(ins[20]) <<< 11) | (longint'(ins[30:21]) <<< 1);
      default: begin r = 0; ill = 1'b1; end
    endcase
    if (xlen == 32) r = r & longint'(64'h0000_0000_FFFF_FFFF);
    return {ill, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit acc;
    bit drn;
    ent_t e;
    if (!reset_n || flush) begin
      mq.delete();
    end else begin
      acc = in_valid && (mq.size() < 2);
      drn = (mq.size() > 0) && out_ready;
      if (drn) void'(mq.pop_front());
      if (acc) begin
        e.ins = Instr;
        e.src = 3'(ImmSrc);
        mq.push_back(e);
      end
    end
  endtask

  task automatic compare_all();
    logic [64:0] e32;
    logic [64:0] e64;
    bit has;
    has = (mq.size() > 0);
    chk("out_valid32", {63'b0, out_valid32}, {63'b0, has});
    chk("out_valid64", {63'b0, out_valid64}, {63'b0, has});
    chk("in_ready32", {63'b0, in_ready32}, {63'b0, mq.size() < 2});
    chk("in_ready64", {63'b0, in_ready64}, {63'b0, mq.size() < 2});
    if (has) begin
      e32 = ref_imm(32, mq[0].ins, mq[0].src);
      e64 = ref_imm(64, mq[0].ins, mq[0].src);
      chk("imm32", {32'b0, Imm32}, e32[63:0]);
      chk("ill32", {63'b0, ill32}, {63'b0, e32[64]});
      chk("imm64", Imm64, e64[63:0]);
      chk("ill64", {63'b0, ill64}, {63'b0, e64[64]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic offer(input logic [2:0] src, input logic [31:0] ins);
    in_valid = 1'b1;
    ImmSrc   = immSrc'(src);
    Instr    = ins;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic lit(input string name, input logic [31:0] e32, input logic [63:0] e64, input logic eill);
    chk({name, "_v32"}, {63'b0, out_valid32}, 64'd1);
    chk({name, "_v64"}, {63'b0, out_valid64}, 64'd1);
    chk({name, "_imm32"}, {32'b0, Imm32}, {32'b0, e32});
    chk({name, "_imm64"}, Imm64, e64);
    chk({name, "_ill32"}, {63'b0, ill32}, {63'b0, eill});
    chk({name, "_ill64"}, {63'b0, ill64}, {63'b0, eill});
  endtask

  task automatic idle_lit(input string name, input logic erdy);
    chk({name, "_v32"}, {63'b0, out_valid32}, 64'd0);
    chk({name, "_v64"}, {63'b0, out_valid64}, 64'd0);
    chk({name, "_rdy32"}, {63'b0, in_ready32}, {63'b0, erdy});
    chk({name, "_rdy64"}, {63'b0, in_ready64}, {63'b0, erdy});
  endtask

  logic [64:0] pin;

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ImmSrc    = Imm11t0;
    Instr     = 32'h0;

    pin = ref_imm(64, 32'hFFF00093, 3'd0); chk("pin_i64", pin[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    pin = ref_imm(32, 32'hFE112E23, 3'd2); chk("pin_s32", pin[63:0], 64'h0000_0000_FFFF_FFFC);
    pin = ref_imm(64, 32'hFE000CE3, 3'd3); chk("pin_b64", pin[63:0], 64'hFFFF_FFFF_FFFF_FFF8);
    pin = ref_imm(64, 32'h800000B7, 3'd4); chk("pin_u64", pin[63:0], 64'hFFFF_FFFF_8000_0000);
    pin = ref_imm(32, 32'h03F09093, 3'd1); chk("pin_sh32", pin[63:0], 64'd31);
    pin = ref_imm(64, 32'h0080006F, 3'd5); chk("pin_j64", pin[63:0], 64'd8);
    pin = ref_imm(64, 32'h12345678, 3'd7); chk("pin_ill", pin, {1'b1, 64'd0});

    tick();
    tick();
    idle_lit("reset", 1'b1);
    chk("reset_imm32", {32'b0, Imm32}, 64'd0);
    chk("reset_imm64", Imm64, 64'd0);
    chk("reset_ill", {62'b0, ill32, ill64}, 64'd0);
    reset_n = 1'b1;
    tick();

    // Formats, with out_ready held high: each entry is visible one cycle after accept.
    idle_lit("pre_t1", 1'b1);
    offer(3'd0, 32'hFFF00093); lit("t1_i", 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    offer(3'd2, 32'hFE112E23); lit("t2_s", 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    offer(3'd3, 32'hFE000CE3); lit("t2_b", 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    offer(3'd4, 32'h123450B7); lit("t2_u", 32'h1234_5000, 64'h0000_0000_1234_5000, 1'b0);
    offer(3'd4, 32'h800000B7); lit("t2_un", 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    offer(3'd5, 32'h0080006F); lit("t2_j", 32'h0000_0008, 64'h0000_0000_0000_0008, 1'b0);
    offer(3'd5, 32'hFFDFF06F); lit("t2_jn", 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    offer(3'd1, 32'h03F09093); lit("t3_sh", 32'd31, 64'd63, 1'b0);
    offer(3'd6, 32'hFFF00093); lit("ill6", 32'd0, 64'd0, 1'b1);
    offer(3'd7, 32'h800000B7); lit("ill7", 32'd0, 64'd0, 1'b1);
    tick();
    idle_lit("t3_end", 1'b1);

    // Back-pressure: A and B fill the buffer, C is held off until space frees.
    out_ready = 1'b0;
    offer(3'd2, 32'hFE112E23);
    offer(3'd4, 32'h123450B7);
    chk("t4_rdy32", {63'b0, in_ready32}, 64'd0);
    chk("t4_rdy64", {63'b0, in_ready64}, 64'd0);
    in_valid = 1'b1; ImmSrc = JType; Instr = 32'h0080006F;
    tick();
    tick();
    chk("t4_hold_rdy", {63'b0, in_ready64}, 64'd0);
    lit("t4_hold_a", 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    out_ready = 1'b1;
    tick();
    lit("t4_b", 32'h1234_5000, 64'h0000_0000_1234_5000, 1'b0);
    tick();
    in_valid = 1'b0;
    lit("t4_c", 32'd8, 64'd8, 1'b0);
    tick();
    idle_lit("t4_end", 1'b1);

    // Flush while full, with a new entry offered in the same cycle.
    out_ready = 1'b0;
    offer(3'd0, 32'hFFF00093);
    offer(3'd2, 32'hFE112E23);
    flush = 1'b1; in_valid = 1'b1; ImmSrc = UType; Instr = 32'h123450B7;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    idle_lit("t5_flush", 1'b1);
    out_ready = 1'b1;
    tick();
    idle_lit("t5_after", 1'b1);

    // Asynchronous reset between edges with the buffer full.
    out_ready = 1'b0;
    offer(3'd3, 32'hFE000CE3);
    offer(3'd5, 32'hFFDFF06F);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    mq.delete();
    #1;
    idle_lit("t6_rst", 1'b1);
    chk("t6_imm32", {32'b0, Imm32}, 64'd0);
    chk("t6_imm64", Imm64, 64'd0);
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick();
    idle_lit("t6_idle", 1'b1);
    offer(3'd4, 32'h800000B7); lit("t6_post", 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
